// File: rtl/demo_input_cond.sv
// demo_input_cond: conditions the raw demo-board push-button and slide
// switches. Every raw input goes through a 2-flop synchronizer and a
// per-channel debounce counter. A three-state FSM then turns the debounced
// button into a start strobe. The strobe is gated by the ready flags of the
// enabled demo masters. Presses that happen while a master is busy are
// counted as rejects.
//
// Optional feature: define DEMO_INPUT_LOCK_EN to freeze the four switch
// outputs while a transaction is in flight or an enabled master is busy.
// When the macro is undefined, the switch outputs are the debounced values
// and no lock logic exists.
module demo_input_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       btn_start_n,
  input  logic       sw_d1_mode,
  input  logic       sw_d2_mode,
  input  logic       sw_d1_en,
  input  logic       sw_d2_en,
  input  logic       d1_ready,
  input  logic       d2_ready,
  output logic       start,
  output logic       d1_mode,
  output logic       d2_mode,
  output logic       d1_en,
  output logic       d2_en,
  output logic [7:0] press_cnt,
  output logic       reject
);

  // Channel order: 0 = button, 1 = d1_mode, 2 = d2_mode, 3 = d1_en, 4 = d2_en.
  localparam int unsigned NCH = 5;
  // The button idles high (released), so its channel resets to 1.
  localparam logic [NCH-1:0] CH_RST = 5'b00001;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRESSED  = 2'd1,
    ST_REJECTED = 2'd2
  } state_e;

  logic [NCH-1:0]                raw;
  logic [NCH-1:0]                sync1_q, sync2_q;
  logic [NCH-1:0]                deb_q, deb_d;
  logic [NCH-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;

  state_e     state_q, state_d;
  logic       start_q, start_d;
  logic       reject_q, reject_d;
  logic [7:0] press_cnt_q;
  logic       cnt_inc;
  logic       deb_start;
  logic       ready_all;
  logic [3:0] sw_out;

  assign raw = {sw_d2_en, sw_d1_en, sw_d2_mode, sw_d1_mode, btn_start_n};

  // Two-flop synchronizers for every raw input.
  // NOTE: sequential state uses <= so all flops sample pre-edge values; = here
  // would collapse the two synchronizer stages into one.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1_q <= CH_RST;
      sync2_q <= CH_RST;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce next state: count cycles of disagreement, flip on the last one.
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Debounced values and counters. A reset discards partial counts.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      deb_q <= CH_RST;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign deb_start = deb_q[0];

`ifdef DEMO_INPUT_LOCK_EN
  logic       lock;
  logic [3:0] sw_out_q;

  assign lock = (state_q == ST_PRESSED) || !ready_all;

  // Switch outputs hold while locked and catch up one cycle after release.
  // Debouncing continues underneath, so no change is lost or restarted.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sw_out_q <= '0;
    end else if (!lock) begin
      sw_out_q <= deb_q[4:1];
    end
  end

  assign sw_out = sw_out_q;
`else
  assign sw_out = deb_q[4:1];
`endif

  assign {d2_en, d1_en, d2_mode, d1_mode} = sw_out;

  // A disabled master never blocks a start.
  assign ready_all = (!d1_en | d1_ready) & (!d2_en | d2_ready);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a press is decided once in IDLE; only a release leaves.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!deb_start) begin
          state_d = ready_all ? ST_PRESSED : ST_REJECTED;
        end
      end
      ST_PRESSED, ST_REJECTED: begin
        if (deb_start) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs. They are decoded from the transition so that the registers
  // below change on the same edge as the state.
  always_comb begin
    start_d  = (state_d != ST_PRESSED);
    reject_d = (state_q == ST_IDLE) && !deb_start && !ready_all;
    cnt_inc  = (state_q == ST_IDLE) && !deb_start && ready_all;
  end

  // Registered start, reject pulse and the wrapping press counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      start_q     <= 1'b1;
      reject_q    <= 1'b0;
      press_cnt_q <= '0;
    end else begin
      start_q  <= start_d;
      reject_q <= reject_d;
      if (cnt_inc) begin
        press_cnt_q <= press_cnt_q + 8'd1;
      end
    end
  end

  assign start     = start_q;
  assign reject    = reject_q;
  assign press_cnt = press_cnt_q;

endmodule

// File: doc/demo_input_cond.md
DEMO_INPUT_COND -- requirements
Module: demo_input_cond

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required before a debounced value changes (range 2 to 65535).
REQ-002 Parameter CNT_WIDTH, default 16: width of each debounce counter.
REQ-003 Port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 Port rstn, input, 1: reset, synchronous and active-low.
REQ-005 Port btn_start_n, input, 1: raw push-button, asynchronous, low = pressed.
REQ-006 Ports sw_d1_mode, sw_d2_mode, sw_d1_en, sw_d2_en, input, 1 each: raw slide switches, asynchronous.
REQ-007 Ports d1_ready, d2_ready, input, 1 each: demo master ready flags fed back from the demo top level.
REQ-008 Port start, output, 1: conditioned start, idle high; a falling edge requests one transaction.
REQ-009 Ports d1_mode, d2_mode, d1_en, d2_en, output, 1 each: conditioned switch values (mode 0 = read, 1 = write).
REQ-010 Port press_cnt, output, 8: count of accepted presses.
REQ-011 Port reject, output, 1: one-cycle pulse for each rejected press.

Function
REQ-012 Each of the 5 raw inputs shall pass through a 2-flop synchronizer before any other use.
REQ-013 Each channel shall have a counter that clears when the synced value equals the debounced value and increments otherwise.
REQ-014 On the DEBOUNCE_CYCLES-th consecutive differing cycle, the debounced value shall take the synced value and the counter shall clear.
REQ-015 Latency from a clean raw edge to the debounced edge shall be exactly 2 + DEBOUNCE_CYCLES cycles.
REQ-016 Any reversion shorter than DEBOUNCE_CYCLES shall leave the debounced value unchanged.
REQ-017 ready_all = (!d1_en | d1_ready) & (!d2_en | d2_ready), using the d1_en and d2_en outputs.
REQ-018 The start FSM shall have three states: IDLE (start=1), PRESSED (start=0) and REJECTED (start=1).
REQ-019 IDLE to PRESSED when debounced start is low and ready_all=1; press_cnt shall increment in the same cycle, wrapping 255 to 0.
REQ-020 IDLE to REJECTED when debounced start is low and ready_all=0; reject shall be high for exactly that one cycle.
REQ-021 PRESSED or REJECTED to IDLE when debounced start returns high; no other exits.
REQ-022 start shall be a registered output of the FSM, so start falls 1 cycle after the debounced start falls.
REQ-023 A held button shall never produce a second press; a new press requires release then press.
REQ-024 If ready_all changes while in PRESSED or REJECTED, there shall be no effect.

Reset
REQ-025 While rstn=0 at a clock edge, the following shall be forced: start=1, d1_mode=d2_mode=d1_en=d2_en=0, press_cnt=0, reject=0, FSM=IDLE, all counters 0, start synchronizer and debounced start = 1, other synchronizers 0.
REQ-026 Reset mid-debounce shall discard partial counts.
REQ-027 A button held through reset release shall be treated as a new press after 2 + DEBOUNCE_CYCLES cycles.

Configuration
REQ-028 Macro DEMO_INPUT_LOCK_EN shall be defined to enable the switch lock.
REQ-029 With DEMO_INPUT_LOCK_EN defined, the four switch outputs shall freeze while FSM=PRESSED or ready_all=0.
REQ-030 With the lock enabled, when the lock releases the outputs shall take the current debounced values on the next cycle.
REQ-031 With DEMO_INPUT_LOCK_EN defined, a switch change during lock shall not restart debounce.
REQ-032 Without DEMO_INPUT_LOCK_EN, the switch outputs shall equal the debounced values at all times, and the lock logic shall not be synthesized.

Verification (DEBOUNCE_CYCLES=4)
REQ-033 Reset check: hold rstn=0 for 3 cycles with random inputs -> start=1, all other outputs 0.
REQ-034 Glitch rejection: btn_start_n low for 3 cycles -> start stays 1 and press_cnt=0.
REQ-035 Accepted press: d1_en=1, d1_ready=1, btn_start_n low for 20 cycles -> start falls 7 cycles after the raw fall, press_cnt=1, start rises 7 cycles after release.
REQ-036 Rejected press: d1_en=1, d1_ready=0, press -> start stays 1, one reject pulse, press_cnt unchanged; after release and a press with d1_ready=1 -> accepted.
REQ-037 Switch lock: with the macro, toggle sw_d1_mode during PRESSED -> d1_mode holds, then updates 1 cycle after IDLE with ready_all=1; without the macro, d1_mode updates 6 cycles after the toggle.
REQ-038 Counter wrap: 256 accepted presses -> press_cnt=0 and no reject pulses.
